im2col_stream: RTL and testbench



---
 rtl/im2col_stream.sv | 203 ++++++++++++++++++++
 tb/tb_im2col_stream.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im2col_stream.sv
// im2col_stream: streams the im2col matrix of a [c][y][x] image straight from
// image memory into the im2col memory, one element per clock, with zero
// padding synthesised on the fly instead of being read from a padded buffer.
//
// Optional build macro: IM2COL_BACKPRESSURE_EN
//   Adds wr_ready_i. A stage-1 write completes only while wr_ready_i is high.
//   While it is low, the counters, addr_rd_o, stage 1 and all outputs hold.
//
// state  | meaning
// IDLE   | waiting for start_i, counters cleared
// ISSUE  | one element per cycle: read address out, pad/index into stage 1
// DRAIN  | last element sits in stage 1 and is written
// FINISH | done_o pulse, then back to IDLE
module im2col_stream #(
  parameter int IMG_C       = 1,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int FILTER_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PAD         = 1,
  parameter int ADDR_STEP   = 1,
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = 'h0000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] addr_rd_o,
  input  logic [DATA_WIDTH-1:0] data_rd_i,
  output logic [ADDR_WIDTH-1:0] addr_wr_o,
  output logic [DATA_WIDTH-1:0] data_wr_o,
  output logic                  mem_wr_en_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef IM2COL_BACKPRESSURE_EN
  ,
  input  logic                  wr_ready_i
`endif
);

  localparam int OUT_W = (IMG_W + 2*PAD - FILTER_SIZE) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2*PAD - FILTER_SIZE) / STRIDE + 1;
  localparam int N     = OUT_H * OUT_W * IMG_C * FILTER_SIZE * FILTER_SIZE;

  // Integer division truncates toward zero, so a kernel larger than the
  // padded image can still yield OUT_W=1; test the raw span as well.
  if ((IMG_W + 2*PAD < FILTER_SIZE) || (IMG_H + 2*PAD < FILTER_SIZE) ||
      (OUT_W <= 0) || (OUT_H <= 0) || (STRIDE <= 0)) begin : g_bad_params
    $error("im2col_stream: illegal geometry, output width or height <= 0");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [31:0]           oy_q, oy_d, ox_q, ox_d, c_q, c_d, ky_q, ky_d, kx_q, kx_d;
  logic [31:0]           n_q, n_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_pad_q, s1_pad_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
  logic [ADDR_WIDTH-1:0] addr_rd_q;

  logic                  stall;
  logic                  issue_go;
  logic                  last_elem;
  logic                  pad_cur;
  int                    y_s, x_s, rd_off;
  logic [ADDR_WIDTH-1:0] addr_cur;

`ifdef IM2COL_BACKPRESSURE_EN
  assign stall = s1_valid_q & ~wr_ready_i;
`else
  assign stall = 1'b0;
`endif

  assign issue_go  = (state_q == S_ISSUE) && !stall;
  assign last_elem = (n_q == 32'(N - 1));

  // Source coordinate, padding decision and read address of the current element
  always_comb begin
    y_s      = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
    x_s      = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
    pad_cur  = (y_s < 0) || (y_s >= IMG_H) || (x_s < 0) || (x_s >= IMG_W);
    rd_off   = ((int'(c_q) * IMG_H + y_s) * IMG_W + x_s) * ADDR_STEP;
    addr_cur = IMG_BASE + ADDR_WIDTH'(rd_off);
  end

  // Padded elements need no read, so the previous address is simply held;
  // during a stall the held address makes the memory re-present the same data.
  assign addr_rd_o = (issue_go && !pad_cur) ? addr_cur : addr_rd_q;

  // FSM and kx -> ky -> c -> ox -> oy counter chain
  always_comb begin
    state_d = state_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    c_d     = c_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        oy_d = '0;
        ox_d = '0;
        c_d  = '0;
        ky_d = '0;
        kx_d = '0;
        n_d  = '0;
        if (start_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue_go) begin
          n_d = n_q + 32'd1;
          if (kx_q == 32'(FILTER_SIZE - 1)) begin
            kx_d = '0;
            if (ky_q == 32'(FILTER_SIZE - 1)) begin
              ky_d = '0;
              if (c_q == 32'(IMG_C - 1)) begin
                c_d = '0;
                if (ox_q == 32'(OUT_W - 1)) begin
                  ox_d = '0;
                  oy_d = oy_q + 32'd1;
                end else begin
                  ox_d = ox_q + 32'd1;
                end
              end else begin
                c_d = c_q + 32'd1;
              end
            end else begin
              ky_d = ky_q + 32'd1;
            end
          end else begin
            kx_d = kx_q + 32'd1;
          end
          if (last_elem) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!stall) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage 1: captures each issued element, releases it once its write completes
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pad_d   = s1_pad_q;
    addr_wr_d  = addr_wr_q;
    if (issue_go) begin
      s1_valid_d = 1'b1;
      s1_pad_d   = pad_cur;
      addr_wr_d  = IM2COL_BASE + ADDR_WIDTH'(n_q * 32'(ADDR_STEP));
    end else if (!stall) begin
      s1_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset aborts any run in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      oy_q       <= '0;
      ox_q       <= '0;
      c_q        <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      n_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_pad_q   <= 1'b0;
      addr_wr_q  <= IM2COL_BASE;
      addr_rd_q  <= IMG_BASE;
    end else begin
      state_q    <= state_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      c_q        <= c_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      n_q        <= n_d;
      s1_valid_q <= s1_valid_d;
      s1_pad_q   <= s1_pad_d;
      addr_wr_q  <= addr_wr_d;
      addr_rd_q  <= addr_rd_o;
    end
  end

  assign mem_wr_en_o = s1_valid_q;
  assign addr_wr_o   = addr_wr_q;
  assign data_wr_o   = (s1_valid_q && !s1_pad_q) ? data_rd_i : '0;
  assign busy_o      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_FINISH);

endmodule

// File: tb/tb_im2col_stream.sv
// Bench for im2col_stream: three instances (default geometry, stride 2 without
// padding, two channels on a 4x4 image), each with a one-cycle-latency image
// memory model. Channel 0 pixel p holds p+1, channel 1 pixel p holds 101+p.
module tb_im2col_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic        wr_ready = 1'b1;

  logic [31:0] ard0, awr0, ard1, awr1, ard2, awr2;
  logic [7:0]  drd0, dwr0, drd1, dwr1, drd2, dwr2;
  logic        en0, busy0, done0, en1, busy1, done1, en2, busy2, done2;

  im2col_stream u_def (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[0]),
    .addr_rd_o(ard0), .data_rd_i(drd0), .addr_wr_o(awr0), .data_wr_o(dwr0),
    .mem_wr_en_o(en0), .busy_o(busy0), .done_o(done0)
`ifdef IM2COL_BACKPRESSURE_EN
    , .wr_ready_i(wr_ready)
`endif
  );

  im2col_stream #(.STRIDE(2), .PAD(0)) u_s2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[1]),
    .addr_rd_o(ard1), .data_rd_i(drd1), .addr_wr_o(awr1), .data_wr_o(dwr1),
    .mem_wr_en_o(en1), .busy_o(busy1), .done_o(done1)
`ifdef IM2COL_BACKPRESSURE_EN
    , .wr_ready_i(1'b1)
`endif
  );

  im2col_stream #(.IMG_C(2), .IMG_W(4), .IMG_H(4)) u_c2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[2]),
    .addr_rd_o(ard2), .data_rd_i(drd2), .addr_wr_o(awr2), .data_wr_o(dwr2),
    .mem_wr_en_o(en2), .busy_o(busy2), .done_o(done2)
`ifdef IM2COL_BACKPRESSURE_EN
    , .wr_ready_i(1'b1)
`endif
  );

  // image memories: registered read
  always @(posedge clk) begin
    drd0 <= 8'(ard0 + 32'd1);
    drd1 <= 8'(ard1 + 32'd1);
    drd2 <= (ard2 < 32'd16) ? 8'(ard2 + 32'd1) : 8'(ard2 + 32'd85);
  end

  int          cur_sel = 0;
  logic [31:0] m_ard, m_awr;
  logic [7:0]  m_dwr;
  logic        m_en, m_busy, m_done, m_ready;

  always_comb begin
    m_ard = ard0; m_awr = awr0; m_dwr = dwr0; m_en = en0; m_busy = busy0; m_done = done0;
    m_ready = wr_ready;
    if (cur_sel == 1) begin
      m_ard = ard1; m_awr = awr1; m_dwr = dwr1; m_en = en1; m_busy = busy1; m_done = done1;
      m_ready = 1'b1;
    end else if (cur_sel == 2) begin
      m_ard = ard2; m_awr = awr2; m_dwr = dwr2; m_en = en2; m_busy = busy2; m_done = done2;
      m_ready = 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;

  int          cap_cnt, done_cnt, done_cyc, done_at_cnt, busy_cnt, stall_bad, stall_cnt;
  bit          timed_out;
  logic [31:0] cap_addr [0:1023];
  logic [7:0]  cap_data [0:1023];

  // Reference element value from index decomposition n -> (oy, ox, c, ky, kx)
  function automatic int exp_data(input int sel, input int n);
    int w, h, cn, k, s, p, ow, kx, ky, c, ox, oy, x, y;
    w = 8; h = 8; cn = 1; k = 3; s = 1; p = 1;
    if (sel == 1) begin s = 2; p = 0; end
    if (sel == 2) begin w = 4; h = 4; cn = 2; end
    ow = (w + 2*p - k) / s + 1;
    kx = n % k;
    ky = (n / k) % k;
    c  = (n / (k*k)) % cn;
    ox = (n / (k*k*cn)) % ow;
    oy = n / (k*k*cn*ow);
    y  = oy*s + ky - p;
    x  = ox*s + kx - p;
    if (y < 0 || y >= h || x < 0 || x >= w) return 0;
    return (c == 0) ? (y*w + x + 1) : (101 + y*w + x);
  endfunction

  task automatic run_capture(input int sel, input int budget, input int restart_at, input bit bp);
    int cyc;
    bit pend;
    logic [31:0] p_awr, p_ard;
    logic [7:0]  p_dwr;
    cur_sel = sel;
    cap_cnt = 0; done_cnt = 0; done_cyc = -1; done_at_cnt = -1; busy_cnt = 0;
    stall_bad = 0; stall_cnt = 0; timed_out = 0; pend = 0; cyc = 0;
    p_awr = '0; p_ard = '0; p_dwr = '0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      start_v = '0;
      if (pend) begin
        if (m_awr !== p_awr || m_dwr !== p_dwr || m_ard !== p_ard || m_en !== 1'b1) stall_bad++;
      end
      pend = 0;
      if (m_busy) busy_cnt++;
      if (m_en && m_ready) begin
        if (cap_cnt < 1024) begin
          cap_addr[cap_cnt] = m_awr;
          cap_data[cap_cnt] = m_dwr;
        end
        if (cap_cnt == restart_at) start_v[sel] = 1'b1;
        cap_cnt++;
      end else if (m_en && !m_ready) begin
        pend = 1; stall_cnt++;
        p_awr = m_awr; p_dwr = m_dwr; p_ard = m_ard;
      end
      if (m_done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; done_at_cnt = cap_cnt; end
      end
      if (bp) wr_ready = 1'($urandom_range(0, 1));
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc >= budget) begin timed_out = 1; break; end
    end
    wr_ready = 1'b1;
    start_v = '0;
  endtask

  task automatic verify_run(input int sel, input int n_exp, input string name);
    int bad_a, bad_d, fa, fd;
    bad_a = 0; bad_d = 0; fa = -1; fd = -1;
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s_timeout: no done within budget, writes=%0d", name, cap_cnt);
    end
    checks++;
    if (cap_cnt != n_exp) begin
      failures++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, cap_cnt, n_exp);
    end
    for (int i = 0; i < cap_cnt && i < 1024; i++) begin
      if (cap_addr[i] !== 32'h2000 + 32'(i)) begin bad_a++; if (fa < 0) fa = i; end
      if (cap_data[i] !== 8'(exp_data(sel, i))) begin bad_d++; if (fd < 0) fd = i; end
    end
    checks++;
    if (bad_a != 0) begin
      failures++;
      $display("FAIL %s_addr: %0d bad, first n=%0d got %h expected %h", name, bad_a, fa,
               cap_addr[fa], 32'h2000 + 32'(fa));
    end
    checks++;
    if (bad_d != 0) begin
      failures++;
      $display("FAIL %s_data: %0d bad, first n=%0d got %0d expected %0d", name, bad_d, fd,
               cap_data[fd], exp_data(sel, fd));
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (done_at_cnt != n_exp) begin
      failures++;
      $display("FAIL %s_done_after_last: writes at done %0d expected %0d", name, done_at_cnt, n_exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (en0 !== 1'b0 || ard0 !== 32'h0 || awr0 !== 32'h2000 || dwr0 !== 8'h0 ||
        busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL %s: en=%b ard=%h awr=%h dwr=%h busy=%b done=%b expected 0 0 2000 0 0 0",
               name, en0, ard0, awr0, dwr0, busy0, done0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_def");
    checks++;
    if (en1 !== 1'b0 || awr1 !== 32'h2000 || ard2 !== 32'h0 || en2 !== 1'b0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_others: en1=%b awr1=%h ard2=%h en2=%b busy2=%b", en1, awr1, ard2, en2, busy2);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_default_run();
    int exp9 [9] = '{0, 0, 0, 0, 1, 2, 0, 9, 10};
    int bad;
    run_capture(0, 2000, -1, 0);
    verify_run(0, 576, "default");
    bad = 0;
    for (int i = 0; i < 9; i++) if (cap_data[i] !== 8'(exp9[i])) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL default_first9: %0d wrong, got %0d %0d %0d %0d %0d %0d %0d %0d %0d",
               bad, cap_data[0], cap_data[1], cap_data[2], cap_data[3], cap_data[4],
               cap_data[5], cap_data[6], cap_data[7], cap_data[8]);
    end
    checks++;
    if (done_cyc != 578) begin
      failures++;
      $display("FAIL default_done_latency: got %0d cycles expected 578", done_cyc);
    end
    checks++;
    if (busy_cnt != 577) begin
      failures++;
      $display("FAIL default_busy_cycles: got %0d expected 577", busy_cnt);
    end
    checks++;
    if (cap_addr[575] !== 32'h223F) begin
      failures++;
      $display("FAIL default_last_addr: got %h expected 223f", cap_addr[575]);
    end
  endtask

  task automatic test_stride2();
    int win [9] = '{21, 22, 23, 29, 30, 31, 37, 38, 39};
    int bad, zeros;
    run_capture(1, 500, -1, 0);
    verify_run(1, 81, "stride2");
    bad = 0; zeros = 0;
    for (int i = 0; i < 9; i++) if (cap_data[45 + i] !== 8'(win[i])) bad++;
    for (int i = 0; i < 81; i++) if (cap_data[i] === 8'h0) zeros++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stride2_window: %0d wrong, n=45 got %0d expected 21", bad, cap_data[45]);
    end
    checks++;
    if (zeros != 0) begin
      failures++;
      $display("FAIL stride2_no_zeros: got %0d zero writes expected 0", zeros);
    end
  endtask

  task automatic test_multichannel();
    run_capture(2, 1000, -1, 0);
    verify_run(2, 288, "multichannel");
    checks++;
    if (cap_data[9] !== 8'd0) begin
      failures++;
      $display("FAIL multichannel_n9: got %0d expected 0", cap_data[9]);
    end
    checks++;
    if (cap_data[13] !== 8'd101) begin
      failures++;
      $display("FAIL multichannel_n13: got %0d expected 101", cap_data[13]);
    end
  endtask

  task automatic test_restart_ignored();
    run_capture(0, 2000, 100, 0);
    verify_run(0, 576, "restart_ignored");
    checks++;
    if (done_cyc != 578) begin
      failures++;
      $display("FAIL restart_ignored_latency: got %0d expected 578", done_cyc);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, wr;
    cur_sel = 0; cyc = 0; wr = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    while (wr < 200 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start_v = '0;
      if (en0) wr++;
    end
    checks++;
    if (wr != 200) begin
      failures++;
      $display("FAIL abort_reach_200: got %0d writes expected 200", wr);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_reset_values");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("abort_stays_idle");
    run_capture(0, 2000, -1, 0);
    verify_run(0, 576, "after_abort");
  endtask

`ifdef IM2COL_BACKPRESSURE_EN
  task automatic test_backpressure();
    run_capture(0, 6000, -1, 1);
    verify_run(0, 576, "backpressure");
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL backpressure_stable: %0d unstable stall cycles expected 0", stall_bad);
    end
    checks++;
    if (stall_cnt == 0) begin
      failures++;
      $display("FAIL backpressure_stalls_seen: got %0d stall cycles expected >0", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_run();
    test_stride2();
    test_multichannel();
    test_restart_ignored();
    test_reset_abort();
`ifdef IM2COL_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
